// File: rtl/cpu_pkg.sv
// Shared datapath definitions for the single-bus CPU: word width, word type
// and the MDR input-select encodings.
package cpu_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef logic [31:0] word_t;

  localparam logic MDR_SEL_BUS = 1'b0;
  localparam logic MDR_SEL_MEM = 1'b1;

endpackage : cpu_pkg

// File: rtl/mux_2to1.sv
// Generic 2:1 multiplexer: sel=0 passes in_0, sel=1 passes in_1.
module mux_2to1 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  output logic [WIDTH-1:0] out_y
);

  // select between the two data inputs
  always_comb begin
    out_y = in_0;
    case (sel)
      1'b0:    out_y = in_0;
      1'b1:    out_y = in_1;
      default: out_y = in_0;
    endcase
  end

endmodule : mux_2to1

// File: rtl/register_en.sv
// Generic datapath register with synchronous clear and load enable;
// clear takes priority over enable.
module register_en #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  // next value when not clearing: load on enable, otherwise hold
  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d_in;
    end else begin
      data_d = data_q;
    end
  end

  // state register with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_out = data_q;

endmodule : register_en

// File: rtl/mdr_register.sv
// Memory Data Register: selects bus or memory data and captures it on
// enable_MDRin; output_Q feeds both the bus mux and memory write data.
module mdr_register
  import cpu_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = cpu_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  read,
  input  logic [DATA_WIDTH-1:0] input_0,
  input  logic [DATA_WIDTH-1:0] input_1,
  input  logic                  enable_MDRin,
  output logic [DATA_WIDTH-1:0] output_Q
);

  logic                  mem_sel_s;
  logic [DATA_WIDTH-1:0] sel_d;

  // decode the control-unit strobe into the mux select
  always_comb begin
    mem_sel_s = 1'b0;
    if (read == MDR_SEL_MEM) begin
      mem_sel_s = 1'b1;
    end else begin
      mem_sel_s = 1'b0;
    end
  end

  mux_2to1 #(
    .WIDTH (DATA_WIDTH)
  ) u_in_mux (
    .sel   (mem_sel_s),
    .in_0  (input_0),
    .in_1  (input_1),
    .out_y (sel_d)
  );

  register_en #(
    .WIDTH       (DATA_WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_mdr_reg (
    .clk   (clk),
    .clr   (clr),
    .en    (enable_MDRin),
    .d_in  (sel_d),
    .q_out (output_Q)
  );

endmodule : mdr_register

// File: tb/tb_mdr_register.sv
// Scoreboard bench for mdr_register: predictions are queued when stimulus
// is driven and compared one time unit after each rising edge.
module tb_mdr_register;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         read = 1'b0;
  logic         enable_MDRin = 1'b0;
  logic [W-1:0] input_0 = 32'h0;
  logic [W-1:0] input_1 = 32'h0;
  logic [W-1:0] output_Q;

  always #5 clk = ~clk;

  mdr_register #(
    .DATA_WIDTH  (W),
    .RESET_VALUE (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .read         (read),
    .input_0      (input_0),
    .input_1      (input_1),
    .enable_MDRin (enable_MDRin),
    .output_Q     (output_Q)
  );

  int           err_cnt = 0;
  int           chk_cnt = 0;
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  logic [W-1:0] model = 32'h0;
  bit           model_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // reference behaviour of the register at one rising edge
  task automatic predict(input string tag);
    if (clr) begin
      model       = 32'h0000_0000;
      model_valid = 1'b1;
    end else if (enable_MDRin) begin
      model       = read ? input_1 : input_0;
      model_valid = 1'b1;
    end
    if (model_valid) begin
      exp_q.push_back(model);
      tag_q.push_back(tag);
    end
  endtask

  task automatic edge_and_compare();
    logic [W-1:0] e;
    string        t;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, output_Q, e);
    end
  endtask

  task automatic cyc(input string tag, input logic c, input logic e, input logic r,
                     input logic [W-1:0] i0, input logic [W-1:0] i1);
    @(negedge clk);
    clr          = c;
    enable_MDRin = e;
    read         = r;
    input_0      = i0;
    input_1      = i1;
    predict(tag);
    edge_and_compare();
  endtask

  initial begin
    // reset wins over enable
    cyc("reset", 1'b1, 1'b1, 1'b0, 32'h1234_5678, 32'h0);
    for (int i = 0; i < 3; i++) cyc("reset_hold", 1'b0, 1'b0, 1'b0, 32'h1234_5678, 32'h0);

    cyc("bus_load",   1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    cyc("mem_load",   1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    cyc("bus_reload", 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D);

    for (int i = 0; i < 4; i++) cyc("hold", 1'b0, 1'b0, i[0], 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    cyc("prio_clr",   1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hA5A5_A5A5);
    cyc("prio_after", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hA5A5_A5A5);

    // mid-cycle input change must not reach output_Q before the edge
    @(negedge clk);
    clr = 1'b0; enable_MDRin = 1'b1; read = 1'b1; input_1 = 32'h1111_1111;
    #2;
    check_eq("no_comb_a", output_Q, model);
    input_1 = 32'h2222_2222;
    #1;
    check_eq("no_comb_b", output_Q, model);
    predict("no_comb_edge");
    edge_and_compare();

    // random traffic with occasional clears
    for (int i = 0; i < 40; i++) begin
      cyc("random", ($urandom_range(0, 9) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom, $urandom);
    end

    check_eq("sb_drain", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_mdr_register
